// File: rtl/iter_addsub.sv
// Multi-cycle add/subtract unit: ripples CHUNK bits per clock, LSB chunk first,
// carrying the carry/borrow between chunks in a flop. Valid/ready on both sides.
module iter_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cb_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cb_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] CHUNK_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("iter_addsub: need WIDTH >= 2, 1 <= CHUNK <= WIDTH, WIDTH %% CHUNK == 0");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             op_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] result_q;
  logic             cb_out_q, zero_q, neg_q, ovf_q;
  logic             in_ready_q, out_valid_q;

  // Chunk datapath: select the current slice, ripple through it, merge it back.
  int unsigned      base;
  logic [WIDTH-1:0] a_shift, b_shift;
  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             ripple;
  logic             carry_d;
  logic [WIDTH-1:0] result_d;
  logic             zero_d, neg_d, ovf_d;

  always_comb begin
    // NOTE: every variable gets a default before any conditional or loop
    // assignment, so no path through this block can infer a latch.
    base      = int'(idx_q) * CHUNK;
    a_shift   = a_q >> base;
    b_shift   = b_q >> base;
    a_chunk   = a_shift[CHUNK-1:0];
    b_chunk   = b_shift[CHUNK-1:0];
    sum_chunk = '0;
    // NOTE: blocking assignments here on purpose -- ripple must carry each
    // bit's result into the next loop iteration within the same evaluation.
    ripple    = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      sum_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ ripple;
      if (op_q) begin
        ripple = (a_chunk[i] & b_chunk[i]) | (ripple & (a_chunk[i] ^ b_chunk[i]));
      end else begin
        ripple = (~a_chunk[i] & b_chunk[i]) | (~(a_chunk[i] ^ b_chunk[i]) & ripple);
      end
    end
    carry_d  = ripple;
    result_d = (result_q & ~(CHUNK_MASK << base)) | (WIDTH'(sum_chunk) << base);

    // Flags only matter on the last chunk, when result_d is the full answer.
    zero_d = (result_d == '0);
    neg_d  = result_d[WIDTH-1];
    if (op_q) begin
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
    end else begin
      ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  // NOTE: state is updated only with non-blocking assignments, so every flop
  // samples the pre-edge value of every other flop regardless of ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      cb_out_q    <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            op_q       <= op;
            carry_q    <= cb_in;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          result_q <= result_d;
          carry_q  <= carry_d;
          idx_q    <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            cb_out_q    <= carry_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Result and flags stay put under backpressure; no new op until IDLE.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cb_out    = cb_out_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/iter_addsub.md
Name: iter_addsub

Overview:
- Parametrised, multi-cycle add/subtract unit for the tinyRISC datapath.
- Successor to the fixed 32-bit ripple-borrow subtractor: configurable width, configurable bits per cycle, add/sub mode, status flags, valid/ready handshake.
- Processes CHUNK bits per clock, LSB chunk first, with the carry/borrow held in a flop between chunks.
- Sits between the register-file read stage and writeback. Shorter ripple path per cycle at the cost of multi-cycle latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- CHUNK, 8, bits processed per BUSY cycle; 1 ≤ CHUNK ≤ WIDTH and WIDTH % CHUNK == 0 (elaboration error otherwise).
- NCHUNK, WIDTH/CHUNK, derived; number of BUSY cycles per operation (localparam).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  unit can accept an operation.
- a  input  WIDTH  minuend / addend.
- b  input  WIDTH  subtrahend / addend.
- op  input  1  0 = SUB (a − b − cb_in), 1 = ADD (a + b + cb_in).
- cb_in  input  1  borrow-in (SUB) or carry-in (ADD).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  difference/sum.
- cb_out  output  1  final borrow-out (SUB) or carry-out (ADD).
- zero  output  1  result == 0.
- neg  output  1  result[WIDTH-1].
- ovf  output  1  signed overflow.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE.
  - in_ready = 1, out_valid = 0.
  - result, cb_out, zero, neg, ovf = 0.
  - Chunk index and internal carry flop = 0.
  - Any in-flight operation is discarded.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On edge with in_valid && in_ready: latch a, b, op, cb_in; carry flop ← cb_in; idx ← 0; → BUSY.
- BUSY:
  - in_ready = 0; in_valid is ignored.
  - Each edge computes chunk idx (bits idx*CHUNK .. idx*CHUNK+CHUNK-1) from the latched operands and the carry flop.
  - Writes that slice of result; carry flop ← chunk carry/borrow out; idx ← idx+1.
  - On the edge processing idx == NCHUNK-1: cb_out ← final carry/borrow, flags computed, → DONE.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge.
  - CHUNK == WIDTH gives 1 cycle.
- DONE:
  - out_valid = 1.
  - result and flags held stable while out_ready = 0 (arbitrary backpressure).
  - On edge with out_valid && out_ready: → IDLE, out_valid ← 0.
  - result/flags retain their values until overwritten by the next op.
- No same-cycle turnaround: in_ready = 0 in DONE.
  - Max throughput is one op per NCHUNK+2 cycles.
- Arithmetic, per bit:
  - SUB: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
  - ADD: s = a ^ b ^ c; c_next = (a & b) | (c & (a ^ b)).
  - Modulo 2^WIDTH; no saturation.
- Flags, computed from the final result:
  - zero: all WIDTH bits 0, independent of cb_out.
  - neg: result MSB.
  - ovf (SUB): (a_msb != b_msb) && (res_msb != a_msb).
  - ovf (ADD): (a_msb == b_msb) && (res_msb != a_msb).
- Reset deassertion mid-handshake: the unit comes up in IDLE. Any consumer-side result is lost; no partial output is ever flagged valid.

Test Plan:
- WIDTH=32, CHUNK=8, SUB, a=0x00000005, b=0x00000003, cb_in=0 -> out_valid 4 cycles after accept; result=0x00000002, cb_out=0, zero=0, neg=0, ovf=0.
- SUB a=0x00000000, b=0x00000001 -> result=0xFFFFFFFF, cb_out=1, neg=1, ovf=0. Repeat with cb_in=1, a=b=0x1234 -> result=0xFFFFFFFF, cb_out=1.
- SUB a=0x80000000, b=0x00000001 -> result=0x7FFFFFFF, ovf=1, cb_out=0. ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1, neg=1.
- ADD a=0xFFFFFFFF, b=0x00000001, cb_in=0 -> result=0, cb_out=1, zero=1. Borrow/carry must propagate across all 4 chunk boundaries.
- Backpressure: hold out_ready=0 for 6 cycles in DONE with in_valid=1 and changing a/b -> result/flags stable, in_ready=0, no new op accepted. out_ready=1 -> IDLE next cycle, new op accepted.
- Assert rst for 1 cycle during BUSY (idx=2) -> outputs zeroed asynchronously, in_ready=1. Next op 10−3 gives 7. Rerun the suite with CHUNK=1 (latency 32) and CHUNK=32 (latency 1).
